// File: rtl/inst_loader.sv
// inst_loader: host program loader for the 64 x 16-bit instruction memory.
// Takes a byte stream (length byte, then big-endian word pairs), writes the
// words to consecutive addresses from 0 with the core held, then releases
// the core with a one-cycle restart pulse.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module inst_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_req,
    input  logic [7:0]        i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_core_hold,
    output logic              o_core_restart,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [ADDR_W:0]   o_word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_RELEASE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_in_ready;
    logic [ADDR_W:0]   r_n;        // words in this session, 1..64
    logic [ADDR_W:0]   w_wc_inc;
    logic              w_xfer;
    logic              w_len_ok;
    logic              w_last;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;     // running XOR of length and data bytes
`endif

    assign w_xfer     = i_in_valid & w_in_ready;
    assign w_len_ok   = (i_in_data[7:6] == 2'b00);
    assign w_wc_inc   = o_word_count + (ADDR_W+1)'(1);
    assign w_last     = (w_wc_inc == r_n);
    assign o_in_ready = w_in_ready;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode; in_ready is the only combinational output.
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            S_IDLE:  if (i_load_req) w_next = S_LEN;
            S_LEN: begin
                w_in_ready = 1'b1;
                if (w_xfer) w_next = w_len_ok ? S_HI : S_IDLE;
            end
            S_HI: begin
                w_in_ready = 1'b1;
                if (w_xfer) w_next = S_LO;
            end
            S_LO: begin
                w_in_ready = 1'b1;
                if (w_xfer) w_next = S_WRITE;
            end
`ifdef LOADER_CHECKSUM_EN
            S_WRITE: w_next = w_last ? S_CHK : S_HI;
            S_CHK: begin
                w_in_ready = 1'b1;
                if (w_xfer) w_next = (i_in_data == r_csum) ? S_RELEASE : S_IDLE;
            end
`else
            S_WRITE: w_next = w_last ? S_RELEASE : S_HI;
`endif
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Registered outputs and session bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wr_en        <= 1'b0;
            o_wr_addr      <= '0;
            o_wr_data      <= '0;
            o_core_hold    <= 1'b1;
            o_core_restart <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
            o_word_count   <= '0;
            r_n            <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum         <= '0;
`endif
        end else begin
            o_wr_en        <= 1'b0;
            o_core_restart <= 1'b0;
            // busy tracks the state the FSM is entering, so it equals state != IDLE
            o_busy         <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: if (i_load_req) begin
                    o_core_hold  <= 1'b1;
                    o_done       <= 1'b0;
                    o_error      <= 1'b0;
                    o_word_count <= '0;
                end
                S_LEN: if (w_xfer) begin
                    // a zero length field encodes a full 64-word load
                    r_n <= (i_in_data[5:0] == 6'd0) ? (ADDR_W+1)'(64)
                                                    : (ADDR_W+1)'(i_in_data[5:0]);
                    if (!w_len_ok) o_error <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    r_csum <= i_in_data;
`endif
                end
                S_HI: if (w_xfer) begin
                    o_wr_data[15:8] <= i_in_data;
`ifdef LOADER_CHECKSUM_EN
                    r_csum <= r_csum ^ i_in_data;
`endif
                end
                S_LO: if (w_xfer) begin
                    o_wr_data[7:0] <= i_in_data;
                    o_wr_en        <= 1'b1;
                    o_wr_addr      <= o_word_count[ADDR_W-1:0];
`ifdef LOADER_CHECKSUM_EN
                    r_csum <= r_csum ^ i_in_data;
`endif
                end
                S_WRITE: o_word_count <= w_wc_inc;
`ifdef LOADER_CHECKSUM_EN
                S_CHK: if (w_xfer && (i_in_data != r_csum)) o_error <= 1'b1;
`endif
                S_RELEASE: begin
                    o_core_restart <= 1'b1;
                    o_core_hold    <= 1'b0;
                    o_done         <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader. A byte-list reference model
// predicts the memory writes and final session status for each load.
module tb_inst_loader;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst, load_req, in_valid, in_ready;
    logic [7:0]        in_data;
    logic              wr_en, core_hold, core_restart, busy, done, error;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   word_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int n_wr, n_restart, first_acc, restart_cyc;
    wr_t exp_q [$];

    inst_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_load_req(load_req),
        .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_core_hold(core_hold), .o_core_restart(core_restart),
        .o_busy(busy), .o_done(done), .o_error(error),
        .o_word_count(word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Write / restart monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en) begin
            n_wr++;
            if (exp_q.size() == 0) chk("wr_extra", 1, 0);
            else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
        if (core_restart) begin
            n_restart++;
            restart_cyc = cyc;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},  32'(in_ready), 0);
        chk({tag, "_wren"}, 32'(wr_en), 0);
        chk({tag, "_addr"}, 32'(wr_addr), 0);
        chk({tag, "_data"}, 32'(wr_data), 0);
        chk({tag, "_hold"}, 32'(core_hold), 1);
        chk({tag, "_rstr"}, 32'(core_restart), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"},  32'(error), 0);
        chk({tag, "_wc"},   32'(word_count), 0);
    endtask

    // Present one byte starting at a negedge; returns at the negedge after it is taken.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rdy_timeout", 1, 0);
        if (first_acc < 0) first_acc = cyc;
        @(negedge clk);
    endtask

    // Append the checksum byte when the feature is built in (optionally corrupted).
    function automatic byte_q_t add_ck(input byte_q_t q, input bit bad);
        logic [7:0] x = 8'h00;
        byte_q_t r = q;
`ifdef LOADER_CHECKSUM_EN
        foreach (q[i]) x ^= q[i];
        r.push_back(bad ? ~x : x);
`else
        x = {7'd0, bad};
`endif
        return r;
    endfunction

    function automatic byte_q_t rand_load(input int n);
        byte_q_t q;
        q.push_back(8'(n % 64));
        for (int i = 0; i < 2 * n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // One full load session checked against the byte-list model.
    task automatic run_session(input string tag, input byte_q_t bytes, input bit gaps, input bit hold_req);
        logic [7:0] len = bytes[0];
        bit  len_err = (len[7:6] != 2'b00);
        int  n = (len[5:0] == 0) ? 64 : int'(len[5:0]);
        bit  ck_ok = 1'b1;
        bit  ok;
        int  t = 0;
        int  nsend;
        logic [7:0] x = len;
        n_wr = 0; n_restart = 0; first_acc = -1; restart_cyc = -1;
        exp_q.delete();
        if (!len_err) begin
            for (int i = 0; i < n; i++) begin
                wr_t e;
                e.addr = ADDR_W'(i);
                e.data = {bytes[1 + 2 * i], bytes[2 + 2 * i]};
                exp_q.push_back(e);
                x ^= bytes[1 + 2 * i] ^ bytes[2 + 2 * i];
            end
`ifdef LOADER_CHECKSUM_EN
            ck_ok = (bytes.size() > 2 * n + 1) && (bytes[2 * n + 1] == x);
`endif
        end
        ok    = !len_err && ck_ok;
        nsend = len_err ? 1 : bytes.size();

        load_req = 1'b1;
        @(negedge clk);
        if (!hold_req) load_req = 1'b0;
        chk({tag, "_start_busy"}, 32'(busy), 1);
        chk({tag, "_start_hold"}, 32'(core_hold), 1);
        chk({tag, "_start_done"}, 32'(done), 0);
        chk({tag, "_start_err"},  32'(error), 0);
        chk({tag, "_start_wc"},   32'(word_count), 0);
        for (int i = 0; i < nsend; i++) send_byte(bytes[i], gaps);
        load_req = 1'b0;
        in_valid = 1'b0;
        if (len_err) chk({tag, "_lenerr_busy"}, 32'(busy), 0);
        while (busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk({tag, "_end_timeout"}, 1, 0);
        @(negedge clk);
        chk({tag, "_nwr"},     32'(n_wr), len_err ? 0 : 32'(n));
        chk({tag, "_pending"}, 32'(exp_q.size()), 0);
        chk({tag, "_done"},    32'(done), 32'(ok));
        chk({tag, "_err"},     32'(error), 32'(!ok));
        chk({tag, "_wc"},      32'(word_count), len_err ? 0 : 32'(n));
        chk({tag, "_hold"},    32'(core_hold), 32'(!ok));
        chk({tag, "_nrestart"}, 32'(n_restart), 32'(ok));
        chk({tag, "_rstr_low"}, 32'(core_restart), 0);
        if (ok && !gaps) begin
`ifdef LOADER_CHECKSUM_EN
            chk({tag, "_latency"}, 32'(restart_cyc - first_acc), 32'(3 + 3 * n));
`else
            chk({tag, "_latency"}, 32'(restart_cyc - first_acc), 32'(2 + 3 * n));
`endif
        end
    endtask

    initial begin
        byte_q_t q, q3;
        rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        n_wr = 0; n_restart = 0; first_acc = -1; restart_cyc = -1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed 2-word load
        q = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        run_session("two_word", add_ck(q, 1'b0), 1'b0, 1'b0);

        // Full 64-word load, no wrap
        run_session("full64", add_ck(rand_load(64), 1'b0), 1'b0, 1'b0);

        // Illegal length byte
        q = {8'h41};
        run_session("badlen", q, 1'b0, 1'b0);

        // Same 3-word program back-to-back, then with random valid gaps
        q3 = add_ck(rand_load(3), 1'b0);
        run_session("w3_b2b", q3, 1'b0, 1'b0);
        run_session("w3_gaps", q3, 1'b1, 1'b1);

        // rst after the HI byte of word 1
        n_wr = 0; first_acc = -1;
        exp_q.delete();
        q = rand_load(3);
        begin
            wr_t e;
            e.addr = '0;
            e.data = {q[1], q[2]};
            exp_q.push_back(e);
        end
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(q[i], 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("midrst");
        chk("midrst_nwr", 32'(n_wr), 1);
        chk("midrst_pending", 32'(exp_q.size()), 0);
        run_session("after_rst", add_ck(rand_load(2), 1'b0), 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        q = {8'h01, 8'h12, 8'h34, 8'h27};
        run_session("ck_good", q, 1'b0, 1'b0);
        q = {8'h01, 8'h12, 8'h34, 8'h00};
        run_session("ck_bad", q, 1'b0, 1'b0);
`endif

        // Random sessions, occasionally with an illegal length
        for (int s = 0; s < 8; s++) begin
            if ($urandom_range(0, 5) == 0) begin
                q = {8'(8'h40 | 8'($urandom_range(0, 191)))};
                run_session("rnd_badlen", q, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                run_session("rnd", add_ck(rand_load(int'($urandom_range(1, 8))),
                            1'($urandom_range(0, 3) == 0)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
